// File: rtl/ubcd_scan_driver.sv
// Multiplexed seven-segment scan driver for the universal BCD glyph set.
// One digit per prescaler slot, ripple blanking across the shadow word, registered outputs.
module ubcd_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000,
  parameter int CW       = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [2:0]            version,
  input  logic [2:0]            extras,
  input  logic                  rbi,
  input  logic                  bi,
  input  logic                  lt,
  input  logic                  al,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     dig,
  output logic                  rbo
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [6:0] EXT_TAB [8][6] = '{
    '{7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00},
    '{7'h58, 7'h4C, 7'h62, 7'h69, 7'h78, 7'h00},
    '{7'h5C, 7'h63, 7'h01, 7'h40, 7'h08, 7'h00},
    '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D},
    '{7'h08, 7'h48, 7'h49, 7'h41, 7'h01, 7'h00},
    '{7'h40, 7'h38, 7'h39, 7'h31, 7'h79, 7'h00},
    '{7'h40, 7'h79, 7'h76, 7'h38, 7'h73, 7'h00},
    '{7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71}
  };

  function automatic logic [6:0] glyph(input logic [3:0] v, input logic [2:0] ver,
                                       input logic [2:0] ext);
    logic [2:0] k;
    k = 3'(v - 4'd10);
    case (v)
      4'd0:    glyph = 7'h3F;
      4'd1:    glyph = 7'h06;
      4'd2:    glyph = 7'h5B;
      4'd3:    glyph = 7'h4F;
      4'd4:    glyph = 7'h66;
      4'd5:    glyph = 7'h6D;
      4'd6:    glyph = ver[0] ? 7'h7D : 7'h7C;
      4'd7:    glyph = ver[1] ? 7'h27 : 7'h07;
      4'd8:    glyph = 7'h7F;
      4'd9:    glyph = ver[2] ? 7'h6F : 7'h67;
      default: glyph = EXT_TAB[ext][k];
    endcase
  endfunction

  logic [CW-1:0]         cnt_q;
  logic [IW-1:0]         idx_q;
  logic [4*DIGITS-1:0]   shadow_q;
  logic [6:0]            seg_q, seg_d;
  logic [DIGITS-1:0]     dig_q, dig_d;
  logic                  rbo_q, rbo_d;

  logic [3:0]            nib_a [DIGITS];
  logic [DIGITS:0]       zero_from;
  logic [3:0]            nib;
  logic                  tc;
  logic                  ripple_blank;
  logic [6:0]            seg_act;

  assign tc = (cnt_q == CW'(PRESCALE - 1));

  // zero_from[k]: nibbles k..DIGITS-1 are all zero; the top entry is vacuously true.
  always_comb begin
    zero_from         = '0;
    zero_from[DIGITS] = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      nib_a[i] = shadow_q[4*i +: 4];
    end
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_from[i] = zero_from[i+1] & (nib_a[i] == 4'd0);
    end
  end

  always_comb begin
    nib          = nib_a[idx_q];
    ripple_blank = ~rbi && (idx_q != '0) && zero_from[idx_q];
    if (!bi)                seg_act = 7'h00;
    else if (!lt)           seg_act = 7'h7F;
    else if (ripple_blank)  seg_act = 7'h00;
    else                    seg_act = glyph(nib, version, extras);
    seg_d        = al ? seg_act : ~seg_act;
    dig_d        = '0;
    dig_d[idx_q] = 1'b1;
    rbo_d        = ~(~rbi && zero_from[1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      dig_q    <= '0;
      rbo_q    <= 1'b1;
      seg_q    <= al ? 7'h00 : 7'h7F;
    end else begin
      if (tc) begin
        cnt_q <= '0;
        idx_q <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (load) shadow_q <= data_in;
      seg_q <= seg_d;
      dig_q <= dig_d;
      rbo_q <= rbo_d;
    end
  end

  assign seg = seg_q;
  assign dig = dig_q;
  assign rbo = rbo_q;

endmodule

// File: tb/tb_ubcd_scan_driver.sv
// Bench for ubcd_scan_driver: a slow-scan (PRESCALE=4) and a fast-scan (PRESCALE=1) instance
// share stimulus; both are checked every cycle against an arithmetic model of the display.
module tb_ubcd_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] data_in = '0;
  logic [2:0]  version = '0;
  logic [2:0]  extras = '0;
  logic        rbi = 1'b1, bi = 1'b1, lt = 1'b1, al = 1'b1;
  logic [6:0]  seg_a, seg_b;
  logic [3:0]  dig_a, dig_b;
  logic        rbo_a, rbo_b;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ubcd_scan_driver #(.DIGITS(4), .PRESCALE(4), .CW(3)) u_dut_a (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .version(version),
    .extras(extras), .rbi(rbi), .bi(bi), .lt(lt), .al(al),
    .seg(seg_a), .dig(dig_a), .rbo(rbo_a));

  ubcd_scan_driver #(.DIGITS(4), .PRESCALE(1), .CW(1)) u_dut_b (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .version(version),
    .extras(extras), .rbi(rbi), .bi(bi), .lt(lt), .al(al),
    .seg(seg_b), .dig(dig_b), .rbo(rbo_b));

  logic [6:0] gtab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7C, 7'h07, 7'h7F, 7'h67};
  logic [6:0] xtab [8][6] = '{
    '{7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00},
    '{7'h58, 7'h4C, 7'h62, 7'h69, 7'h78, 7'h00},
    '{7'h5C, 7'h63, 7'h01, 7'h40, 7'h08, 7'h00},
    '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D},
    '{7'h08, 7'h48, 7'h49, 7'h41, 7'h01, 7'h00},
    '{7'h40, 7'h38, 7'h39, 7'h31, 7'h79, 7'h00},
    '{7'h40, 7'h79, 7'h76, 7'h38, 7'h73, 7'h00},
    '{7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71}
  };

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: slot index from elapsed clocks, glyph from lookup tables.
  typedef struct packed { logic [3:0] dig; logic [6:0] seg; logic rbo; } out_t;

  function automatic out_t predict(input int p, input int t, input logic [15:0] sh);
    out_t       o;
    int         idx;
    int         v;
    logic [6:0] s;
    idx = (t / p) % 4;
    v   = int'((sh >> (4 * idx)) & 16'hF);
    if (!bi)                                        s = 7'h7F & 7'h00;
    else if (!lt)                                   s = 7'h7F;
    else if (!rbi && idx > 0 && (sh >> (4*idx)) == 0) s = 7'h00;
    else if (v < 10) begin
      s = gtab[v];
      if (v == 6 && version[0]) s = 7'h7D;
      if (v == 7 && version[1]) s = 7'h27;
      if (v == 9 && version[2]) s = 7'h6F;
    end else s = xtab[extras][v-10];
    o.seg = al ? s : ~s;
    o.dig = 4'(1 << idx);
    o.rbo = !(!rbi && (sh >> 4) == 0);
    return o;
  endfunction

  out_t ea, eb;
  bit   m_ok = 0;
  int   m_t = 0;
  logic [15:0] m_sh = '0;

  always @(posedge clk) begin
    if (rst) begin
      ea.dig = '0; ea.seg = al ? 7'h00 : 7'h7F; ea.rbo = 1'b1;
      eb = ea;
      m_sh = '0; m_t = 0; m_ok = 1;
    end else if (m_ok) begin
      ea = predict(4, m_t, m_sh);
      eb = predict(1, m_t, m_sh);
      m_t++;
      if (load) m_sh = data_in;
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("model_a", {20'd0, dig_a, seg_a, rbo_a}, {20'd0, ea});
      chk("model_b", {20'd0, dig_b, seg_b, rbo_b}, {20'd0, eb});
    end
  end

  typedef struct {
    logic [15:0] data; logic [2:0] ver; logic [2:0] ext;
    logic rbi; logic bi; logic lt; logic al;
    int digit; logic [6:0] seg; logic rbo;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic [15:0] d, input logic [2:0] ver, input logic [2:0] ext,
                     input logic r, input logic b, input logic l, input logic a,
                     input int dg, input logic [6:0] s, input logic ro);
    vec_t v;
    v.data = d; v.ver = ver; v.ext = ext; v.rbi = r; v.bi = b; v.lt = l; v.al = a;
    v.digit = dg; v.seg = s; v.rbo = ro;
    vecs.push_back(v);
  endtask

  task automatic wait_dig(input logic [3:0] tgt);
    bit ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (dig_a == tgt) ok = 1;
    end
    if (!ok) chk("wait_dig_timeout", {28'd0, dig_a}, {28'd0, tgt});
  endtask

  initial begin
    logic [6:0] scan_seg [4] = '{7'h66, 7'h4F, 7'h5B, 7'h06};

    add(16'h1234, 3'd0, 3'd0, 1, 1, 1, 1, 0, 7'h66, 1);
    add(16'h1234, 3'd0, 3'd0, 1, 1, 1, 1, 3, 7'h06, 1);
    add(16'h0007, 3'd0, 3'd0, 0, 1, 1, 1, 3, 7'h00, 0);
    add(16'h0007, 3'd0, 3'd0, 0, 1, 1, 1, 1, 7'h00, 0);
    add(16'h0007, 3'd0, 3'd0, 0, 1, 1, 1, 0, 7'h07, 0);
    add(16'h0007, 3'd0, 3'd0, 1, 1, 1, 1, 2, 7'h3F, 1);
    add(16'h0007, 3'd2, 3'd0, 0, 1, 1, 1, 0, 7'h27, 0);
    add(16'hABCF, 3'd0, 3'd7, 1, 1, 1, 1, 0, 7'h71, 1);
    add(16'hABCF, 3'd0, 3'd7, 1, 1, 1, 1, 1, 7'h39, 1);
    add(16'hABCF, 3'd0, 3'd7, 1, 1, 1, 1, 3, 7'h77, 1);
    add(16'hABCF, 3'd0, 3'd0, 1, 1, 1, 1, 2, 7'h00, 1);
    add(16'hABCF, 3'd0, 3'd3, 1, 1, 1, 1, 0, 7'h6D, 1);
    add(16'h1234, 3'd0, 3'd0, 1, 1, 0, 1, 1, 7'h7F, 1);
    add(16'h1234, 3'd0, 3'd0, 1, 0, 0, 1, 2, 7'h00, 1);
    add(16'h1234, 3'd0, 3'd0, 1, 0, 0, 0, 2, 7'h7F, 1);
    add(16'h0008, 3'd0, 3'd0, 1, 1, 1, 0, 0, 7'h00, 1);
    add(16'h0050, 3'd0, 3'd0, 0, 1, 1, 1, 2, 7'h00, 1);
    add(16'h0050, 3'd0, 3'd0, 0, 1, 1, 1, 1, 7'h6D, 1);
    add(16'h0967, 3'd7, 3'd0, 1, 1, 1, 1, 1, 7'h7D, 1);
    add(16'h0967, 3'd7, 3'd0, 1, 1, 1, 1, 2, 7'h6F, 1);
    add(16'h000E, 3'd0, 3'd1, 1, 1, 1, 1, 0, 7'h78, 1);
    add(16'h00D0, 3'd0, 3'd5, 1, 1, 1, 1, 1, 7'h31, 1);
    add(16'h0C00, 3'd0, 3'd4, 1, 1, 1, 1, 2, 7'h49, 1);
    add(16'h0007, 3'd0, 3'd0, 0, 1, 0, 1, 3, 7'h7F, 0);

    // Reset state and first edge after release
    @(negedge clk); rst = 1;
    @(negedge clk); @(negedge clk);
    chk("rst_dig", {28'd0, dig_a}, 32'h0);
    chk("rst_seg", {25'd0, seg_a}, 32'h00);
    chk("rst_rbo", {31'd0, rbo_a}, 32'h1);
    chk("rst_dig_b", {28'd0, dig_b}, 32'h0);
    rst = 0;
    @(negedge clk);
    chk("first_dig", {28'd0, dig_a}, 32'h1);
    chk("first_seg", {25'd0, seg_a}, 32'h3F);
    chk("first_dig_b", {28'd0, dig_b}, 32'h1);
    data_in = 16'h1234; load = 1;
    for (int k = 2; k <= 17; k++) begin
      @(negedge clk);
      load = 0;
      chk("scan_dig", {28'd0, dig_a}, 32'(1 << (((k - 1) / 4) % 4)));
      chk("fast_dig", {28'd0, dig_b}, 32'(1 << ((k - 1) % 4)));
      if (k >= 3) chk("scan_seg", {25'd0, seg_a}, {25'd0, scan_seg[((k - 1) / 4) % 4]});
    end

    // Reset mid-scan
    wait_dig(4'b0100);
    rst = 1;
    @(negedge clk);
    chk("mid_rst_dig", {28'd0, dig_a}, 32'h0);
    chk("mid_rst_seg", {25'd0, seg_a}, 32'h00);
    chk("mid_rst_rbo", {31'd0, rbo_a}, 32'h1);
    rst = 0;
    @(negedge clk);
    chk("post_rst_dig", {28'd0, dig_a}, 32'h1);
    chk("post_rst_seg", {25'd0, seg_a}, 32'h3F);

    // Load coinciding with the slot advance
    @(negedge clk);
    @(negedge clk);
    data_in = 16'h5555; load = 1;
    @(negedge clk);
    load = 0;
    chk("adv_old_dig", {28'd0, dig_a}, 32'h1);
    chk("adv_old_seg", {25'd0, seg_a}, 32'h3F);
    @(negedge clk);
    chk("adv_new_dig", {28'd0, dig_a}, 32'h2);
    chk("adv_new_seg", {25'd0, seg_a}, 32'h6D);

    foreach (vecs[i]) begin
      @(negedge clk);
      data_in = vecs[i].data; version = vecs[i].ver; extras = vecs[i].ext;
      rbi = vecs[i].rbi; bi = vecs[i].bi; lt = vecs[i].lt; al = vecs[i].al;
      load = 1;
      @(negedge clk);
      load = 0;
      @(negedge clk);
      wait_dig(4'(1 << vecs[i].digit));
      chk($sformatf("vec%0d_seg", i), {25'd0, seg_a}, {25'd0, vecs[i].seg});
      chk($sformatf("vec%0d_rbo", i), {31'd0, rbo_a}, {31'd0, vecs[i].rbo});
    end

    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      rst  = ($urandom_range(0, 99) == 0);
      load = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       data_in = 16'($urandom);
        1:       data_in = 16'($urandom) & 16'h000F;
        2:       data_in = 16'($urandom) & 16'h00F0;
        default: data_in = 16'($urandom) & 16'h0FFF;
      endcase
      version = 3'($urandom);
      extras  = 3'($urandom);
      rbi = 1'($urandom);
      bi  = ($urandom_range(0, 7) != 0);
      lt  = ($urandom_range(0, 7) != 0);
      al  = 1'($urandom);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
